// File: rtl/reg_dump_reader_pkg.sv
// Shared processor definitions: default register-file geometry and the
// state encoding of the register dump reader.
package reg_dump_reader_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks register-file entries lo_idx..hi_idx through the combinational read
// port and streams each value out as a valid/ready beat, holding core writes.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int DATA = DATA_W,
    parameter int ADDR = ADDR_W
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [ADDR-1:0] lo_idx,
    input  logic [ADDR-1:0] hi_idx,
    output logic [ADDR-1:0] rf_ra,
    input  logic [DATA-1:0] rf_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] out_data,
    output logic [ADDR-1:0] out_idx,
    output logic            out_last,
    output logic            busy,
    output logic            stall_req,
    output logic            done
);

    dump_state_e     state_q, state_d;
    logic [ADDR-1:0] idx_q, idx_d;
    logic [ADDR-1:0] hi_q, hi_d;
    logic [DATA-1:0] out_data_q, out_data_d;
    logic [ADDR-1:0] out_idx_q, out_idx_d;
    logic            out_last_q, out_last_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            hi_q       <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hi_q       <= hi_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            out_last_q <= out_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hi_d       = hi_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;
        rf_ra      = '0;
        out_valid  = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = lo_idx;
                    hi_d    = hi_idx;
                    state_d = (lo_idx <= hi_idx) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                rf_ra      = idx_q;
                out_data_d = rf_rd;
                out_idx_d  = idx_q;
                out_last_d = (idx_q == hi_q);
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    // Compare before incrementing so hi at the top address ends cleanly.
                    if (idx_q == hi_q) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign stall_req = (state_q == ST_FETCH) || (state_q == ST_SEND);
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized and directed checks of reg_dump_reader against a queue-based
// model of the beats each dump request must produce.
module tb_reg_dump_reader;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW-1:0] lo_idx, hi_idx;
    logic [AW-1:0] rf_ra;
    logic [DW-1:0] rf_rd;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          out_last, busy, stall_req, done;

    logic [DW-1:0] rf [NREG];
    assign rf_rd = rf[rf_ra];

    reg_dump_reader #(.DATA(DW), .ADDR(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .lo_idx(lo_idx), .hi_idx(hi_idx),
        .rf_ra(rf_ra), .rf_rd(rf_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .stall_req(stall_req), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] i;
        logic          l;
    } beat_t;

    beat_t q[$];
    int    pending   = 0;
    int    exp_done  = -1;
    int    cyc       = 0;
    int    popped    = 0;
    int    lasts     = 0;
    int    ready_mode = 0;
    int    stall_cnt = 0;
    bit    in_reset  = 1'b1;
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  act, dc;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (!out_valid) begin
                    out_ready = 1'b0;
                    stall_cnt = 0;
                end else if (stall_cnt < 4) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    // Compare process: every cycle, DUT outputs against the model state.
    always @(negedge clk) begin
        if (!in_reset) begin
            act = (pending > 0);
            dc  = (cyc == exp_done);
            chk("busy", busy, act);
            chk("stall_req", stall_req, act && !dc);
            chk("done", done, dc);
            if (!act || dc) chk("rf_ra_idle", rf_ra, 0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("valid_without_beat", 1, 0);
                end else begin
                    chk("out_data", out_data, q[0].d);
                    chk("out_idx", out_idx, q[0].i);
                    chk("out_last", out_last, q[0].l);
                    if (out_ready) begin
                        if (q[0].l) begin
                            exp_done = cyc + 1;
                            lasts++;
                        end
                        popped++;
                        void'(q.pop_front());
                    end
                end
            end
            if (dc) begin
                pending--;
                exp_done = -1;
            end
        end
    end

    task automatic start_dump(input int lo, input int hi);
        @(posedge clk); #1;
        start  = 1'b1;
        lo_idx = AW'(lo);
        hi_idx = AW'(hi);
        @(posedge clk); #1;
        start  = 1'b0;
        lo_idx = AW'($urandom);
        hi_idx = AW'($urandom);
        pending++;
        if (lo > hi) exp_done = cyc;
        else for (int i = lo; i <= hi; i++) q.push_back('{d: rf[i], i: AW'(i), l: (i == hi)});
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 3000 && !ok; n++) begin
            @(negedge clk); #1;
            if (q.size() == 0 && pending == 0) ok = 1'b1;
        end
        if (!ok) begin
            chk("dump_timeout", 1, 0);
            q.delete();
            pending  = 0;
            exp_done = -1;
        end
        @(posedge clk);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; lo_idx = '0; hi_idx = '0; out_ready = 1'b1;
        for (int i = 0; i < NREG; i++) rf[i] = DW'(3 * i);
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_done", done, 0);
        chk("rst_rf_ra", rf_ra, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        #20;
        rstn = 1'b1;
        in_reset = 1'b0;

        // Full dump, always ready: 32 beats, single last, no wrap.
        ready_mode = 0; popped = 0; lasts = 0;
        start_dump(0, 31);
        wait_idle();
        chk("full_beats", popped, 32);
        chk("full_lasts", lasts, 1);

        // Consumer stalls four cycles on every beat.
        ready_mode = 2; popped = 0;
        start_dump(5, 7);
        wait_idle();
        chk("stall_beats", popped, 3);

        // Empty range: done on the second edge, busy for one cycle.
        ready_mode = 0;
        start_dump(9, 4);
        @(negedge clk);
        chk("empty_done_hi", done, 1);
        chk("empty_busy_hi", busy, 1);
        chk("empty_valid", out_valid, 0);
        @(negedge clk);
        chk("empty_done_lo", done, 0);
        chk("empty_busy_lo", busy, 0);
        wait_idle();

        // Single register, with first-beat latency pinned.
        rf[12] = 32'hDEADBEEF;
        start_dump(12, 12);
        @(negedge clk);
        chk("one_fetch_valid", out_valid, 0);
        chk("one_fetch_ra", rf_ra, 12);
        @(negedge clk);
        chk("one_valid", out_valid, 1);
        chk("one_data", out_data, 32'hDEADBEEF);
        chk("one_idx", out_idx, 12);
        chk("one_last", out_last, 1);
        wait_idle();

        // Reset during the third beat of a full dump.
        popped = 0;
        start_dump(0, 31);
        begin
            bit hit = 1'b0;
            for (int n = 0; n < 200 && !hit; n++) begin
                @(negedge clk); #1;
                if (popped >= 2) hit = 1'b1;
            end
            chk("reach_third_beat", hit, 1);
        end
        in_reset = 1'b1;
        rstn = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_stall", stall_req, 0);
        chk("arst_done", done, 0);
        chk("arst_rf_ra", rf_ra, 0);
        chk("arst_data", out_data, 0);
        chk("arst_idx", out_idx, 0);
        chk("arst_last", out_last, 0);
        q.delete(); pending = 0; exp_done = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1 in_reset = 1'b0;
        popped = 0;
        start_dump(2, 3);
        wait_idle();
        chk("after_rst_beats", popped, 2);

        // Start pulses during a dump must be ignored.
        popped = 0;
        start_dump(0, 3);
        for (int n = 0; n < 6; n++) begin
            start = 1'b1; lo_idx = 5'd20; hi_idx = 5'd25;
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_idle();
        chk("ignore_beats", popped, 4);

        // Randomized dumps with random contents and random backpressure.
        ready_mode = 1;
        for (int i = 0; i < NREG; i++) rf[i] = $urandom;
        for (int t = 0; t < 25; t++) begin
            int lo, hi;
            lo = $urandom_range(0, NREG - 1);
            hi = lo + $urandom_range(0, 6);
            if (hi > NREG - 1) hi = NREG - 1;
            if ($urandom_range(0, 4) == 0) hi = (lo == 0) ? 0 : $urandom_range(0, lo - 1);
            start_dump(lo, hi);
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
